// File: rtl/iomem_pkg.sv
// Shared definitions for the PicoSoC iomem bus: arbiter states, bus widths and
// the peripheral address map used by both the decode logic and the DMA engine.
package iomem_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int IOMEM_ADDR_W = 32;
    localparam int IOMEM_DATA_W = 32;

    // Peripheral regions are selected by the top address byte.
    localparam logic [7:0] IOMEM_GPIO   = 8'h03;
    localparam logic [7:0] IOMEM_AUDIO  = 8'h04;
    localparam logic [7:0] IOMEM_VIDEO  = 8'h05;
    localparam logic [7:0] IOMEM_SDCARD = 8'h06;
    localparam logic [7:0] IOMEM_I2C    = 8'h07;

    function automatic logic [7:0] iomem_region(input logic [IOMEM_ADDR_W-1:0] addr);
        return addr[IOMEM_ADDR_W-1 -: 8];
    endfunction

endpackage

// File: rtl/iomem_arb_watchdog.sv
// Transaction watchdog for iomem_arbiter: counts unacknowledged BUSY cycles,
// forces completion at the limit and keeps a sticky error flag.
module iomem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic s_ready,
    input  logic err_clr,
    output logic timeout,
    output logic timeout_err
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic        err_q;

    assign timeout     = active && !s_ready && (cnt_q == LIMIT);
    assign timeout_err = err_q;

    // Counter is held at zero outside a live transaction, so every grant starts fresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (!active) begin
                cnt_q <= '0;
            end else if (!s_ready) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for the PicoSoC iomem bus (CPU = master 0, DMA = master 1).
// Define IOMEM_ARB_TIMEOUT_EN to add the watchdog that completes stuck transactions.
module iomem_arbiter
    import iomem_pkg::*;
#(
    parameter int                 ADDR_W         = IOMEM_ADDR_W,
    parameter int                 DATA_W         = IOMEM_DATA_W,
    parameter int                 TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0]  TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_valid,
    output logic                m0_ready,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_valid,
    output logic                m1_ready,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_valid,
    input  logic                s_ready,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic                owner,
    output logic                timeout_err,
    input  logic                err_clr
);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              own_valid;
    logic              done;
    logic              timeout;
    logic [DATA_W-1:0] resp;

    assign own_valid = owner_q ? m1_valid : m0_valid;
    assign owner     = owner_q;

`ifdef IOMEM_ARB_TIMEOUT_EN
    iomem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .active     ((state_q == ARB_BUSY) && !reset && own_valid),
        .s_ready    (s_ready),
        .err_clr    (err_clr),
        .timeout    (timeout),
        .timeout_err(timeout_err)
    );
`else
    logic        unused_err_clr;
    logic [15:0] unused_limit;
    assign unused_err_clr = err_clr;
    assign unused_limit   = 16'(TIMEOUT_CYCLES);
    assign timeout        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Outputs are suppressed while reset is high so an in-flight transaction never pulses ready.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        s_valid = 1'b0;
        s_wstrb = '0;
        s_addr  = '0;
        s_wdata = '0;
        done    = 1'b0;
        resp    = '0;
        case (state_q)
            ARB_IDLE: begin
                if (m0_valid || m1_valid) begin
                    owner_d = (m0_valid && m1_valid) ? ~last_q : m1_valid;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!reset) begin
                    s_wstrb = owner_q ? m1_wstrb : m0_wstrb;
                    s_addr  = owner_q ? m1_addr  : m0_addr;
                    s_wdata = owner_q ? m1_wdata : m0_wdata;
                    if (!own_valid) begin
                        state_d = ARB_IDLE;
                    end else if (s_ready) begin
                        s_valid = 1'b1;
                        done    = 1'b1;
                        resp    = s_rdata;
                        last_d  = owner_q;
                        state_d = ARB_IDLE;
                    end else if (timeout) begin
                        done    = 1'b1;
                        resp    = TIMEOUT_RDATA;
                        last_d  = owner_q;
                        state_d = ARB_IDLE;
                    end else begin
                        s_valid = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        m0_ready = done && !owner_q;
        m1_ready = done && owner_q;
        m0_rdata = m0_ready ? resp : '0;
        m1_rdata = m1_ready ? resp : '0;
    end

endmodule
